// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs toward if_stage and the fetch PC,
// valid and flush outputs back to the pipeline. The slave modport is the
// if_stage view; the master modport is the surrounding pipeline/driver.
interface if_stage_if;
  logic        stall_if_i;
  logic        jump_decision_i;
  logic [31:0] jump_target_i;
  logic        branch_taken_ex_i;
  logic [31:0] branch_target_ex_i;
  logic [31:0] pc_if_o;
  logic        fetch_valid_o;
  logic        flush_id_o;
  logic        flush_ex_o;

  modport slave (
    input  stall_if_i,
    input  jump_decision_i,
    input  jump_target_i,
    input  branch_taken_ex_i,
    input  branch_target_ex_i,
    output pc_if_o,
    output fetch_valid_o,
    output flush_id_o,
    output flush_ex_o
  );

  modport master (
    output stall_if_i,
    output jump_decision_i,
    output jump_target_i,
    output branch_taken_ex_i,
    output branch_target_ex_i,
    input  pc_if_o,
    input  fetch_valid_o,
    input  flush_id_o,
    input  flush_ex_o
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, picks the next PC from
// PC+4 / ID JAL redirect / EX branch-JALR redirect, holds under stall and
// defers a redirect that lands during a stall until the stall clears.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned RESET_WAIT = 2
) (
  input  logic         clk,
  input  logic         rst,
  if_stage_if.slave    bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_cnt_o,
  output logic [31:0]  redirect_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(RESET_WAIT - 1);

  state_t      state_q;
  logic [3:0]  wait_cnt_q;
  logic [31:0] pc_q;
  logic [31:0] pend_q;
  logic        fetch_valid_q;

  logic        ex_redir;
  logic        id_redir;
  logic        redir;
  logic [31:0] redir_target;

  // Redirect selection: EX wins over ID since its instruction is older; ID
  // jumps only count in RUN because ID was already flushed on entering PEND.
  always_comb begin
    ex_redir     = bus.branch_taken_ex_i && (state_q != S_WAIT);
    id_redir     = bus.jump_decision_i && (state_q == S_RUN);
    redir        = ex_redir || id_redir;
    redir_target = ex_redir ? {bus.branch_target_ex_i[31:2], 2'b00}
                            : {bus.jump_target_i[31:2], 2'b00};
  end

  // Flushes are combinational so wrong-path work is killed in the redirect cycle.
  always_comb begin
    bus.flush_ex_o = ex_redir;
    bus.flush_id_o = ex_redir || id_redir;
  end

  assign bus.pc_if_o       = pc_q;
  assign bus.fetch_valid_o = fetch_valid_q;

  // Fetch FSM: reset settle wait, running fetch, and deferred redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_WAIT;
      wait_cnt_q    <= '0;
      pc_q          <= BOOT_ADDR;
      pend_q        <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 4'd1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_q       <= S_RUN;
            fetch_valid_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (redir) begin
            if (bus.stall_if_i) begin
              pend_q        <= redir_target;
              state_q       <= S_PEND;
              fetch_valid_q <= 1'b0;
            end else begin
              pc_q <= redir_target;
            end
          end else if (!bus.stall_if_i) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        S_PEND: begin
          if (!bus.stall_if_i) begin
            // A same-cycle EX redirect supersedes the stored target.
            pc_q          <= ex_redir ? redir_target : pend_q;
            state_q       <= S_RUN;
            fetch_valid_q <= 1'b1;
          end else if (ex_redir) begin
            pend_q <= redir_target;
          end
        end
        default: begin
          state_q       <= S_WAIT;
          wait_cnt_q    <= '0;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] redirect_cnt_q;

  // Performance counters: unstalled RUN fetches and accepted redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if ((state_q == S_RUN) && !bus.stall_if_i) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (redir) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o    = fetch_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage (BOOT_ADDR=0, RESET_WAIT=2): a table of per-cycle
// vectors whose expected outputs go through a scoreboard queue, then
// hand-written sequences for async reset in PEND and the optional counters.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;
`endif

  if_stage #(
    .BOOT_ADDR (32'h0000_0000),
    .RESET_WAIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt),
    .redirect_cnt_o(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        jd;
    logic [31:0] jt;
    logic        bt;
    logic [31:0] btgt;
    logic [31:0] pc;
    logic        fv;
    logic        fid;
    logic        fex;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        fv;
    logic        fid;
    logic        fex;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic stall, input logic jd, input logic [31:0] jt,
                              input logic bt, input logic [31:0] btgt,
                              input logic [31:0] pc, input logic fv,
                              input logic fid, input logic fex);
    vec_t v;
    v.stall = stall; v.jd = jd; v.jt = jt; v.bt = bt; v.btgt = btgt;
    v.pc = pc; v.fv = fv; v.fid = fid; v.fex = fex;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic jd, input logic [31:0] jt,
                       input logic bt, input logic [31:0] btgt);
    bus.stall_if_i         = stall;
    bus.jump_decision_i    = jd;
    bus.jump_target_i      = jt;
    bus.branch_taken_ex_i  = bt;
    bus.branch_target_ex_i = btgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    exp_t got;

    //          stall jd  jt            bt  btgt          pc            fv fid fex
    vecs.push_back(mk(0, 1, 32'h40,       1, 32'h200,       32'h0,        0, 0, 0)); // WAIT ignores redirects
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,         32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,         32'h0,        1, 0, 0)); // first RUN
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,         32'h4,        1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,         32'h8,        1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,         32'hC,        1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h40,       0, 32'h0,         32'h10,       1, 1, 0)); // JAL
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,         32'h40,       1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h80,       1, 32'h200,       32'h44,       1, 1, 1)); // EX beats ID
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h123,       32'h200,      1, 1, 1)); // stalled redirect
    vecs.push_back(mk(1, 1, 32'h80,       0, 32'h0,         32'h200,      0, 0, 0)); // PEND ignores JAL
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,         32'h200,      0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,         32'h200,      0, 0, 0)); // stall drops
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,         32'h120,      1, 0, 0)); // aligned pending
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,         32'h124,      1, 0, 0)); // plain stall holds
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFE,0, 32'h0,         32'h124,      1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,         32'hFFFF_FFFC,1, 0, 0));
    vecs.push_back(mk(1, 1, 32'h300,      0, 32'h0,         32'h0,        1, 1, 0)); // wrapped; JAL while stalled
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h501,       32'h0,        0, 1, 1)); // EX overwrites pending
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h602,       32'h0,        0, 1, 1)); // same-cycle EX on release
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,         32'h600,      1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,         32'h604,      1, 0, 0));

    drive(0, 1, 32'h40, 1, 32'h200);
    #2;
    check("rst_pc", bus.pc_if_o, 32'h0);
    check("rst_fv", {31'b0, bus.fetch_valid_o}, 32'h0);
    check("rst_fid", {31'b0, bus.flush_id_o}, 32'h0);
    check("rst_fex", {31'b0, bus.flush_ex_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].jd, vecs[i].jt, vecs[i].bt, vecs[i].btgt);
      e.idx = i; e.pc = vecs[i].pc; e.fv = vecs[i].fv; e.fid = vecs[i].fid; e.fex = vecs[i].fex;
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      check($sformatf("pc[%0d]", got.idx), bus.pc_if_o, got.pc);
      check($sformatf("fv[%0d]", got.idx), {31'b0, bus.fetch_valid_o}, {31'b0, got.fv});
      check($sformatf("fid[%0d]", got.idx), {31'b0, bus.flush_id_o}, {31'b0, got.fid});
      check($sformatf("fex[%0d]", got.idx), {31'b0, bus.flush_ex_o}, {31'b0, got.fex});
      @(posedge clk);
      #1;
    end

    // Enter PEND with a deferred JAL, then reset asynchronously mid-cycle.
    drive(1, 1, 32'h700, 0, 32'h0);
    @(negedge clk);
    check("pend_entry_pc", bus.pc_if_o, 32'h608);
    check("pend_entry_fid", {31'b0, bus.flush_id_o}, 32'h1);
    @(posedge clk);
    #1 drive(1, 0, 32'h0, 0, 32'h0);
    check("pend_fv", {31'b0, bus.fetch_valid_o}, 32'h0);
    check("pend_pc", bus.pc_if_o, 32'h608);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", bus.pc_if_o, 32'h0);
    check("async_rst_fv", {31'b0, bus.fetch_valid_o}, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rwait0_pc", bus.pc_if_o, 32'h0);
    check("rwait0_fv", {31'b0, bus.fetch_valid_o}, 32'h0);
    @(negedge clk);
    check("rwait1_fv", {31'b0, bus.fetch_valid_o}, 32'h0);
    @(negedge clk);
    check("rrun0_pc", bus.pc_if_o, 32'h0);
    check("rrun0_fv", {31'b0, bus.fetch_valid_o}, 32'h1);
    @(negedge clk);
    check("rrun1_pc_no_pending", bus.pc_if_o, 32'h4);

`ifdef IF_PERF_CNT_EN
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("cnt_rst_fetch", fetch_cnt, 32'h0);
    check("cnt_rst_redir", redirect_cnt, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4)       drive(0, 0, 32'h0, 0, 32'h0);
      else if (k == 4) drive(0, 1, 32'h800, 0, 32'h0);
      else             drive(1, 0, 32'h0, 0, 32'h0);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 32'h0, 0, 32'h0);
    check("cnt_fetch", fetch_cnt, 32'd5);
    check("cnt_redir", redirect_cnt, 32'd1);
`endif

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
